// File: rtl/if_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage.
//   NOP_INST_WORD : encoding of sll $0,$0,0, the word placed in IF/ID on a bubble
//   if_state_t    : fetch FSM states
//     FETCH - request outstanding at req_addr
//     HOLD  - word already fetched but parked because the pipe is frozen
//     DRAIN - waiting out a response that a flush made stale
package if_stage_pkg;

  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst         : clock, synchronous active-high reset (reset = bubble)
//   bubble_i         : load NOP_INST, pc4 = 0, valid = 0 (wins over load_i)
//   load_i           : capture inst_i / pc4_i as a real instruction
//   inst_i, pc4_i    : incoming instruction and its PC+4
//   inst_o, pc4_o    : registered instruction and PC+4
//   valid_o          : 1 = real instruction, 0 = bubble
// With neither control asserted the register holds its contents.
module ifid_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS core, including the IF/ID register.
//   clk, rst              : clock, synchronous active-high reset
//   Write                 : hazard unit; 1 = advance PC and IF/ID, 0 = freeze both
//   flush, redirect_pc    : branch/jump resolved in ID; squash fetch and redirect
//   imem_req, imem_addr   : instruction-memory request (addr stable while waiting)
//   imem_ready, imem_rdata: response handshake and data
//   inst_id, pc4_id       : IF/ID instruction and its PC+4
//   valid_id              : IF/ID holds a real instruction
//   fetch_stall           : request outstanding but not answered this cycle
// pc_q is the architectural fetch PC; req_addr_q is what memory is being asked for.
// They only differ in DRAIN, where memory still owns the stale address and pc_q
// already points at the redirect target.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Write,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic        fetch_stall
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic        ifid_load, ifid_bubble;
  logic [31:0] ifid_inst;
  logic [31:0] pc_inc, redir;

  // Wraps naturally modulo 2^32.
  assign pc_inc = pc_q + 32'd4;
  // Redirect targets are word aligned regardless of what ID supplies.
  assign redir  = redirect_pc & ~32'h3;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_inst_d = hold_inst_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_inst   = imem_rdata;

    case (state_q)
      FETCH: begin
        if (flush) begin
          ifid_bubble = 1'b1;
          pc_d        = redir;
          // An unanswered request cannot be withdrawn: keep its address and
          // swallow the response in DRAIN.
          if (imem_ready) req_addr_d = redir;
          else            state_d    = DRAIN;
        end else if (imem_ready) begin
          if (Write) begin
            ifid_load  = 1'b1;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end else begin
            // Pipe frozen: park the word so it is neither lost nor refetched.
            hold_inst_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (Write) begin
          ifid_bubble = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          ifid_bubble = 1'b1;
          pc_d        = redir;
          req_addr_d  = redir;
          state_d     = FETCH;
        end else if (Write) begin
          ifid_load  = 1'b1;
          ifid_inst  = hold_inst_q;
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        ifid_bubble = flush | Write;
        if (flush) pc_d = redir;
        if (imem_ready) begin
          // Stale response discarded; resume at the newest target.
          req_addr_d = flush ? redir : pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_inst_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign imem_req    = (state_q != HOLD);
  assign imem_addr   = req_addr_q;
  assign fetch_stall = imem_req & ~imem_ready;

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .bubble_i(ifid_bubble),
    .inst_i  (ifid_inst),
    .pc4_i   (pc_inc),
    .inst_o  (inst_id),
    .pc4_o   (pc4_id),
    .valid_o (valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage. Each row gives the inputs for one
// cycle, the request-side outputs expected before the edge, and the IF/ID
// contents expected after it.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, Write, flush, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_id, fetch_stall;
  logic [31:0] imem_addr, inst_id, pc4_id;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .Write      (Write),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst_id    (inst_id),
    .pc4_id     (pc4_id),
    .valid_id   (valid_id),
    .fetch_stall(fetch_stall)
  );

  typedef struct {
    logic        rst, wr, fl;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        chk_pre;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] inst, pc4;
    logic        valid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic w, logic f, logic [31:0] rpc, logic rdy,
                              logic [31:0] rdata, logic cp, logic req, logic [31:0] addr,
                              logic stall, logic [31:0] inst, logic [31:0] pc4, logic valid);
    vec_t v;
    v.rst = r; v.wr = w; v.fl = f; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
    v.chk_pre = cp; v.req = req; v.addr = addr; v.stall = stall;
    v.inst = inst; v.pc4 = pc4; v.valid = valid;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive at the falling edge, check request side, clock, check IF/ID.
  task automatic apply(vec_t v, int row);
    @(negedge clk);
    rst = v.rst; Write = v.wr; flush = v.fl; redirect_pc = v.rpc;
    imem_ready = v.rdy; imem_rdata = v.rdata;
    #1;
    if (v.chk_pre) begin
      chk("imem_req",    row, {31'b0, imem_req},    {31'b0, v.req});
      chk("imem_addr",   row, imem_addr,            v.addr);
      chk("fetch_stall", row, {31'b0, fetch_stall}, {31'b0, v.stall});
    end
    @(posedge clk);
    #1;
    chk("inst_id",  row, inst_id,              v.inst);
    chk("pc4_id",   row, pc4_id,               v.pc4);
    chk("valid_id", row, {31'b0, valid_id},    {31'b0, v.valid});
  endtask

  initial begin
    int row;
    rst = 1'b1; Write = 1'b1; flush = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    //               rst wr fl rpc            rdy rdata          cp req addr          st  inst           pc4            v
    // reset for two cycles
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        1, 32'h0,        32'h0,        0));
    // first cycle out of reset, memory not ready: bubble
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        1, 32'h0,        32'h0,        0));
    // zero-wait streaming
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8C010004, 1, 1, 32'h0,        0, 32'h8C010004, 32'h4,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h00221820, 1, 1, 32'h4,        0, 32'h00221820, 32'h8,        1));
    // Write=0 while 0x8 returns: parked in HOLD, IF/ID held
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00431020, 1, 1, 32'h8,        0, 32'h00221820, 32'h8,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h8,        0, 32'h00221820, 32'h8,        1));
    // release: parked word delivered, no refetch (rdata ignored, req=0)
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h8,        0, 32'h00431020, 32'hC,        1));
    // flush while 0xC is waiting: DRAIN keeps 0xC until ready
    tbl.push_back(mk(0, 1, 1, 32'h100,      0, 32'h0,        1, 1, 32'hC,        1, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'hC,        1, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hBAD0BAD0, 1, 1, 32'hC,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h012A4020, 1, 1, 32'h100,      0, 32'h012A4020, 32'h104,      1));
    // flush with ready: word dropped, redirect immediately
    tbl.push_back(mk(0, 1, 1, 32'h40,       1, 32'h11111111, 1, 1, 32'h104,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h22222222, 1, 1, 32'h40,       0, 32'h22222222, 32'h44,       1));
    // flush with Write=0, unaligned target, then a second flush in DRAIN wins
    tbl.push_back(mk(0, 0, 1, 32'h83,       0, 32'h0,        1, 1, 32'h44,       1, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        1, 1, 32'h44,       1, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h33333333, 1, 1, 32'h44,       0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h44444444, 1, 1, 32'h200,      0, 32'h44444444, 32'h204,      1));
    // frozen and waiting, then park, then flush out of HOLD
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h204,      1, 32'h44444444, 32'h204,      1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h55555555, 1, 1, 32'h204,      0, 32'h44444444, 32'h204,      1));
    tbl.push_back(mk(0, 0, 1, 32'h300,      0, 32'h0,        1, 0, 32'h204,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h66666666, 1, 1, 32'h300,      0, 32'h66666666, 32'h304,      1));
    // PC+4 wrap
    tbl.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 1, 32'h0,        1, 1, 32'h304,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h77777777, 1, 1, 32'hFFFFFFFC, 0, 32'h77777777, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h88888888, 1, 1, 32'h0,        0, 32'h88888888, 32'h4,        1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    row = tbl.size();

    // Reset while parked in HOLD.
    apply(mk(0, 0, 0, 32'h0,   1, 32'h99999999, 1, 1, 32'h4, 0, 32'h88888888, 32'h4, 1), row++);
    apply(mk(1, 1, 0, 32'h0,   0, 32'h0,        1, 0, 32'h4, 0, 32'h0,        32'h0, 0), row++);
    apply(mk(0, 1, 0, 32'h0,   1, 32'hAAAAAAAA, 1, 1, 32'h0, 0, 32'hAAAAAAAA, 32'h4, 1), row++);

    // Long DRAIN: address must stay put for every waiting cycle, then reset.
    apply(mk(0, 1, 1, 32'h500, 0, 32'h0,        1, 1, 32'h4, 1, 32'h0,        32'h0, 0), row++);
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 0, 32'h0, 0, 32'hCCCCCCCC, 1, 1, 32'h4, 1, 32'h0,        32'h0, 0), row++);
    apply(mk(1, 1, 0, 32'h0,   0, 32'h0,        1, 1, 32'h4, 1, 32'h0,        32'h0, 0), row++);
    apply(mk(0, 1, 0, 32'h0,   0, 32'h0,        1, 1, 32'h0, 1, 32'h0,        32'h0, 0), row++);
    apply(mk(0, 1, 0, 32'h0,   1, 32'hBBBBBBBB, 1, 1, 32'h0, 0, 32'hBBBBBBBB, 32'h4, 1), row++);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
